data_arb: RTL and testbench



---
 rtl/data_arb.sv | 154 +++++++++++++++
 tb/tb_data_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_arb.sv
// data_arb: round-robin burst arbiter that shares one registered data_t
// valid/ready channel among N_REQ producers and tags each beat with its source.
package data_arb_pkg;
  typedef struct packed {
    logic [7:0] data;
  } data_t;
endpackage

module data_arb
  import data_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_valid,
  input  data_t                    i_data [N_REQ],
  output logic [N_REQ-1:0]         o_ready,
  output logic                     o_valid,
  output data_t                    o_data,
  output logic [$clog2(N_REQ)-1:0] o_src,
  input  logic                     i_ready,
  output logic                     o_busy
);

  localparam int unsigned SRC_W  = $clog2(N_REQ);
  localparam int unsigned SCAN_W = SRC_W + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [SRC_W-1:0]  owner_q;
  logic [SRC_W-1:0]  ptr_q;
  logic [SRC_W-1:0]  ptr_nxt;
  logic [SRC_W-1:0]  grant_idx;
  logic [SCAN_W-1:0] scan;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant_found;
  logic              own_valid;
  logic              own_ready;
  logic              accept;
  logic              last_beat;

  // First requesting index at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = {1'b0, ptr_q} + SCAN_W'(i);
      if (scan >= SCAN_W'(N_REQ)) begin
        scan = scan - SCAN_W'(N_REQ);
      end
      if (!grant_found && i_valid[scan[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[SRC_W-1:0];
      end
    end
  end

  // Pointer moves just past the releasing owner.
  always_comb begin
    ptr_nxt = (owner_q == SRC_W'(N_REQ - 1)) ? '0 : owner_q + SRC_W'(1);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: release on saturation or when the owner stops requesting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = OWN;
        end
      end
      OWN: begin
        if (!own_valid || last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; only the owner can see ready, and only if the
  // output register has room this cycle.
  always_comb begin
    o_ready   = '0;
    o_busy    = (state_q == OWN);
    own_valid = i_valid[owner_q];
    own_ready = !o_valid || i_ready;
    accept    = 1'b0;
    if (state_q == OWN) begin
      o_ready[owner_q] = own_ready;
      accept           = own_valid && own_ready;
    end
    last_beat = accept && ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST));
  end

  // Grant bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && grant_found) begin
        owner_q <= grant_idx;
        cnt_q   <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == OWN && state_d == IDLE) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

  // Output register drains on i_ready independently of the grant state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_data  <= i_data[owner_q];
      o_src   <= owner_q;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_ready));

  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_src)));

endmodule

// File: tb/tb_data_arb.sv
// Scoreboard bench for data_arb: producer queues feed the DUT, expected
// {src, data, spacing} entries are queued per scenario and popped on output.
module tb_data_arb;
  import data_arb_pkg::*;

  localparam int unsigned N = 4;

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] i_valid;
  data_t        i_data [N];
  logic         i_ready;

  logic [N-1:0] rdy_a, rdy_b, rdy;
  logic         ov_a, ov_b, ov;
  data_t        od_a, od_b, od;
  logic [1:0]   src_a, src_b, src;
  logic         busy_a, busy_b, busy;
  logic         sel_b;

  exp_t         exp_q [$];
  logic [7:0]   prod_mem [N][16];
  int           head [N];
  int           tail [N];
  int           n_chk, n_fail, cyc, last_x;
  logic         stall, use_pat;
  logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  string        tname;

  always #5 clk = ~clk;

  data_arb #(.N_REQ(N), .MAX_BURST(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_ready(rdy_a), .o_valid(ov_a), .o_data(od_a), .o_src(src_a),
    .i_ready(i_ready), .o_busy(busy_a)
  );

  data_arb #(.N_REQ(N), .MAX_BURST(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_ready(rdy_b), .o_valid(ov_b), .o_data(od_b), .o_src(src_b),
    .i_ready(i_ready), .o_busy(busy_b)
  );

  assign rdy  = sel_b ? rdy_b  : rdy_a;
  assign ov   = sel_b ? ov_b   : ov_a;
  assign od   = sel_b ? od_b   : od_a;
  assign src  = sel_b ? src_b  : src_a;
  assign busy = sel_b ? busy_b : busy_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h (t=%0t)", tname, tag, obs, exp, $time);
    end
  endtask

  task automatic add_beat(input int r, input logic [7:0] d);
    prod_mem[r][tail[r]] = d;
    tail[r]++;
  endtask

  task automatic expect_beat(input int s, input logic [7:0] d, input int gap);
    exp_t e;
    e.src  = 2'(s);
    e.data = d;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < N; r++) begin
      if (head[r] != tail[r]) begin
        i_valid[r]     = 1'b1;
        i_data[r].data = prod_mem[r][head[r]];
      end else begin
        i_valid[r] = 1'b0;
        i_data[r]  = '0;
      end
    end
  endtask

  task automatic clear_all();
    for (int r = 0; r < N; r++) begin
      head[r] = 0;
      tail[r] = 0;
    end
    exp_q.delete();
  endtask

  // One cycle: drive at negedge, sample 1 ns later, score transfers and accepts.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    i_ready = stall ? 1'b0 : (use_pat ? pat[cyc % 4] : 1'b1);
    drive_inputs();
    #1;
    check("onehot", 32'($countones(rdy) <= 1), 32'd1);
    if (rdy != '0) check("busy", 32'(busy), 32'd1);
    if (ov && !i_ready) begin
      check("stall_rdy", 32'(rdy), 32'd0);
      if (exp_q.size() > 0) begin
        check("held_data", 32'(od.data), 32'(exp_q[0].data));
        check("held_src", 32'(src), 32'(exp_q[0].src));
      end
    end
    if (ov && i_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("src", 32'(src), 32'(e.src));
        check("data", 32'(od.data), 32'(e.data));
        if (e.gap > 0) check("gap", 32'(cyc - last_x), 32'(e.gap));
        last_x = cyc;
      end
    end
    for (int r = 0; r < N; r++) begin
      if (i_valid[r] && rdy[r]) head[r]++;
    end
  endtask

  task automatic run_test();
    int budget;
    budget = 0;
    last_x = cyc + 1;
    while (exp_q.size() > 0 && budget < 300) begin
      step();
      budget++;
    end
    check("timeout", 32'(exp_q.size()), 32'd0);
    repeat (4) step();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n   = 1'b0;
    stall   = 1'b0;
    use_pat = 1'b0;
    i_ready = 1'b1;
    clear_all();
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_x = 0;
    rst_n = 1'b0; sel_b = 1'b0; stall = 1'b0; use_pat = 1'b0; i_ready = 1'b1;
    clear_all();
    drive_inputs();

    tname = "reset";
    repeat (2) @(negedge clk);
    #1;
    check("o_valid", 32'(ov_a), 32'd0);
    check("o_data", 32'(od_a.data), 32'd0);
    check("o_src", 32'(src_a), 32'd0);
    check("o_ready", 32'(rdy_a), 32'd0);
    check("o_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;

    tname = "single";
    reset_dut();
    for (int k = 0; k < 6; k++) add_beat(2, 8'(8'h10 + k));
    expect_beat(2, 8'h10, 2); expect_beat(2, 8'h11, 1);
    expect_beat(2, 8'h12, 1); expect_beat(2, 8'h13, 1);
    expect_beat(2, 8'h14, 2); expect_beat(2, 8'h15, 1);
    run_test();

    tname = "fair";
    reset_dut();
    for (int k = 0; k < 8; k++) add_beat(0, 8'(8'h40 + k));
    for (int r = 1; r < N; r++)
      for (int k = 0; k < 4; k++) add_beat(r, 8'(8'h40 + r * 16 + k));
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 4; k++) expect_beat(r, 8'(8'h40 + r * 16 + k), (k == 0) ? 2 : 1);
    for (int k = 4; k < 8; k++) expect_beat(0, 8'(8'h40 + k), (k == 4) ? 2 : 1);
    run_test();

    tname = "backpressure";
    reset_dut();
    use_pat = 1'b1;
    for (int k = 0; k < 4; k++) begin
      add_beat(0, 8'(8'hA0 + k));
      expect_beat(0, 8'(8'hA0 + k), 0);
    end
    run_test();
    use_pat = 1'b0;

    tname = "early";
    reset_dut();
    add_beat(1, 8'h31); add_beat(1, 8'h32);
    add_beat(3, 8'h33); add_beat(3, 8'h34);
    expect_beat(1, 8'h31, 2); expect_beat(1, 8'h32, 1);
    expect_beat(3, 8'h33, 3); expect_beat(3, 8'h34, 1);
    run_test();

    tname = "rst_mid";
    reset_dut();
    stall = 1'b1;
    for (int k = 0; k < 8; k++) add_beat(0, 8'(8'hC0 + k));
    expect_beat(0, 8'hC0, 0);
    repeat (4) step();
    check("pre_valid", 32'(ov_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("o_valid", 32'(ov_a), 32'd0);
    check("o_data", 32'(od_a.data), 32'd0);
    check("o_src", 32'(src_a), 32'd0);
    check("o_ready", 32'(rdy_a), 32'd0);
    check("o_busy", 32'(busy_a), 32'd0);
    stall = 1'b0;
    clear_all();
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    add_beat(3, 8'hD3); add_beat(1, 8'hD1);
    expect_beat(1, 8'hD1, 2); expect_beat(3, 8'hD3, 3);
    run_test();

    tname = "burst1";
    reset_dut();
    sel_b = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 2; k++) add_beat(r, 8'(8'hE0 + r * 2 + k));
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 3; r++) expect_beat(r, 8'(8'hE0 + r * 2 + k), 2);
    run_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
